core_cycle_watchdog_ctrl: RTL and testbench
===========================================

CORE_CYCLE_WATCHDOG_CTRL -- requirements
Module: core_cycle_watchdog_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of the cycle counter and the limit.
REQ-002 Parameter: WARN_MARGIN, default 1024, number of cycles before the limit at which warn asserts.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 limit  input  CNT_W  max-cycle budget, sampled only on an accepted start; 0 = watchdog disabled.
REQ-007 start  input  1  begin a run; honoured only in IDLE.
REQ-008 halt  input  1  core halted/debug; suspends counting.
REQ-009 kick  input  1  restart the budget; clears the counter.
REQ-010 done  input  1  test finished; suppresses expiry.
REQ-011 clear  input  1  return from EXPIRED or DONE to IDLE.
REQ-012 cycle_count  output  CNT_W  registered cycle counter.
REQ-013 state  output  3  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3, DONE=4.
REQ-014 warn  output  1  level: budget nearly consumed.
REQ-015 timeout  output  1  one-cycle pulse on entry to EXPIRED.
REQ-016 expired  output  1  level: high while in EXPIRED.

Function
REQ-017 IDLE: cycle_count SHALL be 0; start SHALL latch limit into limit_q and go to RUN next cycle.
REQ-018 RUN: cycle_count SHALL increment by 1 per cycle, saturating at all-ones (no wrap).
REQ-019 Priority in RUN, evaluated on registered values: done > expiry > kick > halt > increment.
REQ-020 Expiry condition: limit_q != 0 and cycle_count >= limit_q and done == 0; next state EXPIRED, count holds.
REQ-021 done in RUN or PAUSE SHALL go to DONE next cycle with count held, even if the expiry condition is true that cycle.
REQ-022 kick in RUN or PAUSE SHALL load cycle_count to 0 next cycle, and state SHALL remain unchanged.
REQ-023 halt in RUN SHALL go to PAUSE, with the count held that cycle; PAUSE holds the count and returns to RUN when halt drops.
REQ-024 Expiry SHALL NOT be evaluated in PAUSE.
REQ-025 timeout SHALL be 1 only during the first cycle in EXPIRED.
REQ-026 expired SHALL be 1 for every cycle in EXPIRED, and EXPIRED SHALL be left only via clear or reset.
REQ-027 clear in EXPIRED or DONE SHALL go to IDLE with count 0; clear SHALL be ignored in any other state.
REQ-028 start SHALL be ignored outside IDLE, and limit changes outside IDLE SHALL have no effect.
REQ-029 warn SHALL be 1 iff the state is RUN or PAUSE, limit_q != 0, and cycle_count >= limit_q - WARN_MARGIN.
REQ-030 If limit_q <= WARN_MARGIN, warn SHALL be 1 whenever the state is RUN or PAUSE and limit_q != 0; the subtraction SHALL NOT underflow.
REQ-031 With limit_q == 0 the block SHALL count normally, and expired, timeout and warn SHALL never assert.

Reset
REQ-032 reset_n low SHALL immediately force state=IDLE, cycle_count=0, limit_q=0, warn=0, timeout=0 and expired=0, independent of clock.
REQ-033 Reset asserted mid-run or in EXPIRED SHALL discard all progress; after release the block SHALL wait in IDLE for start.

Verification
REQ-034 limit=5, start pulse at edge 0 -> RUN at edge 1 with count 0; count=5 at edge 6; EXPIRED plus a single-cycle timeout at edge 7; count holds at 5.
REQ-035 limit=5, done=1 at the edge where count=5 -> DONE next cycle; timeout/expired never assert; clear -> IDLE with count 0.
REQ-036 limit=100, halt high for 10 cycles at count 40 -> PAUSE, count stays 40, then resumes 41 after halt drops; kick at count 60 -> count 0, expiry pushed out.
REQ-037 limit=2000, WARN_MARGIN=1024 -> warn rises when count=976; limit=10 -> warn high from the first RUN cycle.
REQ-038 limit=0 and CNT_W=4 -> count saturates at 15; no warn, timeout or expired.
REQ-039 reset_n pulsed low asynchronously mid-RUN and in EXPIRED -> all outputs 0 and state IDLE immediately; start required to resume.

Source files
------------

// File: rtl/core_cycle_watchdog_ctrl.sv
// Cycle-budget watchdog for a core under test: counts run cycles against a latched
// limit, warns near the budget, and latches an expiry until explicitly cleared.
module core_cycle_watchdog_ctrl #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned WARN_MARGIN = 1024
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [CNT_W-1:0] limit,
   input  logic             start,
   input  logic             halt,
   input  logic             kick,
   input  logic             done,
   input  logic             clear,
   output logic [CNT_W-1:0] cycle_count,
   output logic [2:0]       state,
   output logic             warn,
   output logic             timeout,
   output logic             expired
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PAUSE   = 3'd2,
      S_EXPIRED = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Warn arithmetic is done one bit wider than the larger of the counter and the
   // margin, so a margin bigger than the limit never wraps around.
   localparam int unsigned XW = ((CNT_W > 32) ? CNT_W : 32) + 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [XW-1:0]    MARGIN_X = XW'(WARN_MARGIN);

   state_t           state_q;
   logic [CNT_W-1:0] limit_q;
   logic [XW-1:0]    limit_x;
   logic [XW-1:0]    count_x;
   logic             limit_on;
   logic             expire_hit;
   logic             warn_zone;

   assign limit_on   = (limit_q != '0);
   assign expire_hit = limit_on && (cycle_count >= limit_q);

   assign limit_x   = XW'(limit_q);
   assign count_x   = XW'(cycle_count);
   assign warn_zone = (limit_x <= MARGIN_X) || (count_x >= (limit_x - MARGIN_X));

   assign state = state_q;
   assign warn  = ((state_q == S_RUN) || (state_q == S_PAUSE)) && limit_on && warn_zone;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cycle_count <= '0;
         limit_q     <= '0;
         timeout     <= 1'b0;
         expired     <= 1'b0;
      end else begin
         // NOTE: non-blocking default; only the RUN->EXPIRED branch overrides it, which
         // makes timeout a single-cycle pulse without a separate edge detector.
         timeout <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cycle_count <= '0;
               if (start) begin
                  limit_q <= limit;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (done) begin
                  state_q <= S_DONE;
               end else if (expire_hit) begin
                  state_q <= S_EXPIRED;
                  timeout <= 1'b1;
                  expired <= 1'b1;
               end else if (kick) begin
                  cycle_count <= '0;
               end else if (halt) begin
                  state_q <= S_PAUSE;
               end else if (cycle_count != CNT_MAX) begin
                  cycle_count <= cycle_count + 1'b1;
               end
            end
            // Expiry is deliberately not checked while paused.
            S_PAUSE: begin
               if (done) begin
                  state_q <= S_DONE;
               end else if (kick) begin
                  cycle_count <= '0;
               end else if (!halt) begin
                  state_q <= S_RUN;
               end
            end
            S_EXPIRED, S_DONE: begin
               if (clear) begin
                  state_q     <= S_IDLE;
                  cycle_count <= '0;
                  expired     <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               cycle_count <= '0;
               expired     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_cycle_watchdog_ctrl.sv
// Bench for core_cycle_watchdog_ctrl: directed scenarios plus random traffic against
// a cycle-level behavioural model, on a 32-bit and a 4-bit instance sharing controls.
module tb_core_cycle_watchdog_ctrl;

   localparam int unsigned MARGIN32 = 1024;
   localparam int unsigned MARGIN4  = 3;

   logic        clock;
   logic        reset_n;
   logic [31:0] limit;
   logic [3:0]  limit4;
   logic        start, halt, kick, done, clear;

   logic [31:0] count32;
   logic [2:0]  state32;
   logic        warn32, tmo32, exp32;
   logic [3:0]  count4;
   logic [2:0]  state4;
   logic        warn4, tmo4, exp4;

   int n_checks = 0;
   int n_errors = 0;

   core_cycle_watchdog_ctrl #(.CNT_W(32), .WARN_MARGIN(MARGIN32)) dut (
      .clock(clock), .reset_n(reset_n), .limit(limit), .start(start), .halt(halt),
      .kick(kick), .done(done), .clear(clear), .cycle_count(count32), .state(state32),
      .warn(warn32), .timeout(tmo32), .expired(exp32)
   );

   core_cycle_watchdog_ctrl #(.CNT_W(4), .WARN_MARGIN(MARGIN4)) dut4 (
      .clock(clock), .reset_n(reset_n), .limit(limit4), .start(start), .halt(halt),
      .kick(kick), .done(done), .clear(clear), .cycle_count(count4), .state(state4),
      .warn(warn4), .timeout(tmo4), .expired(exp4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: state numbers follow the published state codes.
   localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_EXP = 3, ST_DONE = 4;

   typedef struct {
      int              st;
      longint unsigned cnt;
      longint unsigned lim;
      bit              tmo;
   } mdl_t;

   mdl_t m32, m4;

   function automatic mdl_t mreset();
      mdl_t r;
      r.st = ST_IDLE; r.cnt = 0; r.lim = 0; r.tmo = 0;
      return r;
   endfunction

   function automatic mdl_t mstep(mdl_t m, longint unsigned lim_in, longint unsigned maxv);
      mdl_t n = m;
      n.tmo = 0;
      case (m.st)
         ST_IDLE: begin
            n.cnt = 0;
            if (start) begin n.lim = lim_in; n.st = ST_RUN; end
         end
         ST_RUN: begin
            if (done)                              n.st = ST_DONE;
            else if (m.lim != 0 && m.cnt >= m.lim) begin n.st = ST_EXP; n.tmo = 1; end
            else if (kick)                         n.cnt = 0;
            else if (halt)                         n.st = ST_PAUSE;
            else if (m.cnt < maxv)                 n.cnt = m.cnt + 1;
         end
         ST_PAUSE: begin
            if (done)       n.st = ST_DONE;
            else if (kick)  n.cnt = 0;
            else if (!halt) n.st = ST_RUN;
         end
         default: if (clear) begin n.st = ST_IDLE; n.cnt = 0; end
      endcase
      return n;
   endfunction

   function automatic logic [37:0] exp_vec(mdl_t m, longint unsigned margin);
      bit w;
      w = (m.st == ST_RUN || m.st == ST_PAUSE) && m.lim != 0 && (m.cnt + margin >= m.lim);
      return {3'(m.st), 32'(m.cnt), w, m.tmo, (m.st == ST_EXP)};
   endfunction

   function automatic logic [37:0] obs32();
      return {state32, count32, warn32, tmo32, exp32};
   endfunction

   function automatic logic [37:0] obs4();
      return {state4, 28'd0, count4, warn4, tmo4, exp4};
   endfunction

   function automatic logic [37:0] vec(int st, longint unsigned cnt, bit w, bit t, bit e);
      return {3'(st), 32'(cnt), w, t, e};
   endfunction

   // One clock edge: DUT and models advance together, outputs settle 1 time unit later.
   task automatic tick();
      @(posedge clock);
      m32 = mstep(m32, limit, 64'hFFFF_FFFF);
      m4  = mstep(m4, limit4, 64'd15);
      #1;
   endtask

   task automatic run_to(int n);
      repeat (n) tick();
   endtask

   task automatic pulse_reset(string tag);
      #3 reset_n = 1'b0;
      m32 = mreset();
      m4  = mreset();
      #1;
      if (obs32() !== vec(ST_IDLE, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL %s async32: got %h want %h", tag, obs32(), vec(ST_IDLE, 0, 0, 0, 0));
      end
      n_checks++;
      if (obs4() !== vec(ST_IDLE, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL %s async4: got %h want %h", tag, obs4(), vec(ST_IDLE, 0, 0, 0, 0));
      end
      n_checks++;
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      if (obs32() !== vec(ST_IDLE, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL reset32: got %h want %h", obs32(), vec(ST_IDLE, 0, 0, 0, 0));
      end
      n_checks++;
      tick();
      if (obs4() !== vec(ST_IDLE, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL reset4_idle: got %h want %h", obs4(), vec(ST_IDLE, 0, 0, 0, 0));
      end
      n_checks++;
   endtask

   task automatic test_expiry();
      limit = 5; limit4 = 0; start = 1;
      tick();
      start = 0;
      if (obs32() !== vec(ST_RUN, 0, 1, 0, 0)) begin
         n_errors++; $display("FAIL expiry_start: got %h want %h", obs32(), vec(ST_RUN, 0, 1, 0, 0));
      end
      n_checks++;
      run_to(5);
      if (obs32() !== vec(ST_RUN, 5, 1, 0, 0)) begin
         n_errors++; $display("FAIL expiry_at_limit: got %h want %h", obs32(), vec(ST_RUN, 5, 1, 0, 0));
      end
      n_checks++;
      tick();
      if (obs32() !== vec(ST_EXP, 5, 0, 1, 1)) begin
         n_errors++; $display("FAIL expiry_entry: got %h want %h", obs32(), vec(ST_EXP, 5, 0, 1, 1));
      end
      n_checks++;
      start = 1; kick = 1; halt = 1; limit = 7;
      tick();
      start = 0; kick = 0; halt = 0;
      if (obs32() !== vec(ST_EXP, 5, 0, 0, 1)) begin
         n_errors++; $display("FAIL expiry_hold: got %h want %h", obs32(), vec(ST_EXP, 5, 0, 0, 1));
      end
      n_checks++;
      clear = 1;
      tick();
      clear = 0;
      if (obs32() !== vec(ST_IDLE, 0, 0, 0, 0)) begin
         n_errors++; $display("FAIL expiry_clear: got %h want %h", obs32(), vec(ST_IDLE, 0, 0, 0, 0));
      end
      n_checks++;
   endtask

   task automatic test_done();
      limit = 5; start = 1;
      tick();
      start = 0;
      run_to(5);
      done = 1;
      tick();
      done = 0;
      if (obs32() !== vec(ST_DONE, 5, 0, 0, 0)) begin
         n_errors++; $display("FAIL done_over_expiry: got %h want %h", obs32(), vec(ST_DONE, 5, 0, 0, 0));
      end
      n_checks++;
      run_to(3);
      if (obs32() !== vec(ST_DONE, 5, 0, 0, 0)) begin
         n_errors++; $display("FAIL done_hold: got %h want %h", obs32(), vec(ST_DONE, 5, 0, 0, 0));
      end
      n_checks++;
      clear = 1;
      tick();
      clear = 0;
      if (obs32() !== vec(ST_IDLE, 0, 0, 0, 0)) begin
         n_errors++; $display("FAIL done_clear: got %h want %h", obs32(), vec(ST_IDLE, 0, 0, 0, 0));
      end
      n_checks++;
   endtask

   task automatic test_halt_kick();
      limit = 100; start = 1;
      tick();
      start = 0;
      run_to(40);
      halt = 1;
      tick();
      if (obs32() !== vec(ST_PAUSE, 40, 1, 0, 0)) begin
         n_errors++; $display("FAIL halt_enter: got %h want %h", obs32(), vec(ST_PAUSE, 40, 1, 0, 0));
      end
      n_checks++;
      run_to(9);
      halt = 0;
      tick();
      tick();
      if (obs32() !== vec(ST_RUN, 41, 1, 0, 0)) begin
         n_errors++; $display("FAIL halt_resume: got %h want %h", obs32(), vec(ST_RUN, 41, 1, 0, 0));
      end
      n_checks++;
      run_to(19);
      kick = 1;
      tick();
      kick = 0;
      if (obs32() !== vec(ST_RUN, 0, 1, 0, 0)) begin
         n_errors++; $display("FAIL kick_clear: got %h want %h", obs32(), vec(ST_RUN, 0, 1, 0, 0));
      end
      n_checks++;
      run_to(100);
      if (obs32() !== vec(ST_RUN, 100, 1, 0, 0)) begin
         n_errors++; $display("FAIL kick_pushout: got %h want %h", obs32(), vec(ST_RUN, 100, 1, 0, 0));
      end
      n_checks++;
      tick();
      if (obs32() !== vec(ST_EXP, 100, 0, 1, 1)) begin
         n_errors++; $display("FAIL kick_late_expiry: got %h want %h", obs32(), vec(ST_EXP, 100, 0, 1, 1));
      end
      n_checks++;
      clear = 1;
      tick();
      clear = 0;
   endtask

   task automatic test_warn();
      limit = 2000; start = 1;
      tick();
      start = 0;
      run_to(975);
      if (obs32() !== vec(ST_RUN, 975, 0, 0, 0)) begin
         n_errors++; $display("FAIL warn_below: got %h want %h", obs32(), vec(ST_RUN, 975, 0, 0, 0));
      end
      n_checks++;
      tick();
      if (obs32() !== vec(ST_RUN, 976, 1, 0, 0)) begin
         n_errors++; $display("FAIL warn_rise: got %h want %h", obs32(), vec(ST_RUN, 976, 1, 0, 0));
      end
      n_checks++;
      done = 1;
      tick();
      done = 0; clear = 1;
      tick();
      clear = 0; limit = 10; start = 1;
      tick();
      start = 0;
      if (obs32() !== vec(ST_RUN, 0, 1, 0, 0)) begin
         n_errors++; $display("FAIL warn_small_limit: got %h want %h", obs32(), vec(ST_RUN, 0, 1, 0, 0));
      end
      n_checks++;
      done = 1;
      tick();
      done = 0; clear = 1;
      tick();
      clear = 0;
   endtask

   task automatic test_saturate();
      limit = 0; limit4 = 0; start = 1;
      tick();
      start = 0;
      run_to(20);
      if (obs4() !== vec(ST_RUN, 15, 0, 0, 0)) begin
         n_errors++; $display("FAIL saturate4: got %h want %h", obs4(), vec(ST_RUN, 15, 0, 0, 0));
      end
      n_checks++;
      if (obs32() !== vec(ST_RUN, 20, 0, 0, 0)) begin
         n_errors++; $display("FAIL nolimit32: got %h want %h", obs32(), vec(ST_RUN, 20, 0, 0, 0));
      end
      n_checks++;
      done = 1;
      tick();
      done = 0; clear = 1;
      tick();
      clear = 0;
   endtask

   task automatic test_async_reset();
      limit = 50; limit4 = 9; start = 1;
      tick();
      start = 0;
      run_to(10);
      pulse_reset("mid_run");
      run_to(3);
      if (obs32() !== vec(ST_IDLE, 0, 0, 0, 0)) begin
         n_errors++; $display("FAIL wait_for_start: got %h want %h", obs32(), vec(ST_IDLE, 0, 0, 0, 0));
      end
      n_checks++;
      limit = 3; start = 1;
      tick();
      start = 0;
      run_to(4);
      if (obs32() !== vec(ST_EXP, 3, 0, 1, 1)) begin
         n_errors++; $display("FAIL pre_reset_expired: got %h want %h", obs32(), vec(ST_EXP, 3, 0, 1, 1));
      end
      n_checks++;
      pulse_reset("in_expired");
      tick();
      if (obs32() !== vec(ST_IDLE, 0, 0, 0, 0)) begin
         n_errors++; $display("FAIL post_reset_idle: got %h want %h", obs32(), vec(ST_IDLE, 0, 0, 0, 0));
      end
      n_checks++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         start  = ($urandom_range(0, 2) == 0);
         halt   = ($urandom_range(0, 3) == 0);
         kick   = ($urandom_range(0, 19) == 0);
         done   = ($urandom_range(0, 39) == 0);
         clear  = ($urandom_range(0, 7) == 0);
         limit  = $urandom_range(0, 40);
         limit4 = 4'($urandom_range(0, 15));
         tick();
         if (obs32() !== exp_vec(m32, MARGIN32)) begin
            n_errors++;
            $display("FAIL random32 cycle %0d: got %h want %h", i, obs32(), exp_vec(m32, MARGIN32));
         end
         n_checks++;
         if (obs4() !== exp_vec(m4, MARGIN4)) begin
            n_errors++;
            $display("FAIL random4 cycle %0d: got %h want %h", i, obs4(), exp_vec(m4, MARGIN4));
         end
         n_checks++;
      end
      start = 0; halt = 0; kick = 0; done = 0; clear = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      limit = 0; limit4 = 0;
      start = 0; halt = 0; kick = 0; done = 0; clear = 0;
      m32 = mreset();
      m4  = mreset();
      #12 reset_n = 1'b1;
      #1;
      test_reset();
      test_expiry();
      test_done();
      test_halt_kick();
      test_warn();
      test_saturate();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
